// File: rtl/read_nonsym_pattern_source.sv
// read_nonsym_pattern_source
//   Host-readable pattern source. A generator fills a 64-bit-wide buffer with
//   pairs of 32-bit pattern words, one entry per cycle while not full. The host
//   drains it one 32-bit half per pipe_out_read strobe, high half first, so it
//   sees p0, p1, p2, ... in order. A free-running timer sits alongside.
//
// Ports
//   okClk          clock
//   reset          synchronous active-high reset
//   pattern_mode   [1:0] pattern select, latched on reset_pattern
//   reset_pattern  pulse: latch mode, reseed generator, flush buffer, clear stats
//   start_timer    pulse: start timer
//   stop_timer     pulse: stop timer (wins over start)
//   pipe_out_read  read strobe, one word per asserted cycle
//   pipe_out_data  read data, valid one cycle after the strobe, held otherwise
//   clk_counts     64-bit timer count
//   timer_on       timer running
//   words_read     successful reads (wrapping)
//   underrun_count reads while empty (saturating)
//   buf_empty      no half available
module read_nonsym_pattern_source #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
    input  logic        okClk,
    input  logic        reset,
    input  logic [31:0] pattern_mode,
    input  logic        reset_pattern,
    input  logic        start_timer,
    input  logic        stop_timer,
    input  logic        pipe_out_read,
    output logic [31:0] pipe_out_data,
    output logic [63:0] clk_counts,
    output logic        timer_on,
    output logic [31:0] words_read,
    output logic [31:0] underrun_count,
    output logic        buf_empty
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    // Right-shift Galois form of x^32+x^22+x^2+x+1.
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    function automatic logic [31:0] pattern_step(input logic [1:0] mode, input logic [31:0] p);
        logic [31:0] n;
        unique case (mode)
            2'd0: n = p + 32'd1;
            2'd1: n = (p >> 1) ^ (p[0] ? LFSR_MASK : 32'h0);
            2'd2: n = {p[30:0], p[31]};
            default: n = ~p;  // A5A5_A5A5 <-> 5A5A_5A5A
        endcase
        return n;
    endfunction

    function automatic logic [31:0] pattern_seed(input logic [1:0] mode);
        logic [31:0] s;
        unique case (mode)
            2'd0: s = 32'h0;
            2'd1: s = LFSR_SEED;
            2'd2: s = 32'h1;
            default: s = 32'hA5A5_A5A5;
        endcase
        return s;
    endfunction

    logic [63:0]           mem [DEPTH];
    logic [1:0]            mode_q;
    logic [31:0]           gen_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  half_q;
    logic [31:0]           data_q, words_q, under_q;
    logic                  empty_q;
    logic [63:0]           clk_counts_q;
    logic                  timer_on_q;

    logic        full, empty_now, do_push, do_read, do_underrun, do_pop;
    logic [31:0] gen_1, gen_2, head_half;
    logic [63:0] head;

    logic unused_mode_bits;
    assign unused_mode_bits = ^pattern_mode[31:2];

    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty_now   = (count_q == '0);
        // reset_pattern flushes everything, so it suppresses both sides.
        do_push     = !full && !reset_pattern;
        do_read     = pipe_out_read && !empty_now && !reset_pattern;
        do_underrun = pipe_out_read && empty_now && !reset_pattern;
        do_pop      = do_read && half_q;
        gen_1       = pattern_step(mode_q, gen_q);
        gen_2       = pattern_step(mode_q, gen_1);
        head        = mem[rd_ptr_q];
        head_half   = half_q ? head[31:0] : head[63:32];
        count_d     = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Buffer storage, no reset needed: occupancy tracking guards all reads.
    always_ff @(posedge okClk) begin
        if (!reset && do_push) begin
            mem[wr_ptr_q] <= {gen_q, gen_1};
        end
    end

    always_ff @(posedge okClk) begin
        if (reset) begin
            mode_q   <= 2'd0;
            gen_q    <= 32'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            half_q   <= 1'b0;
            data_q   <= 32'h0;
            words_q  <= 32'h0;
            under_q  <= 32'h0;
            empty_q  <= 1'b1;
        end else if (reset_pattern) begin
            mode_q   <= pattern_mode[1:0];
            gen_q    <= pattern_seed(pattern_mode[1:0]);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            half_q   <= 1'b0;
            words_q  <= 32'h0;
            under_q  <= 32'h0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                gen_q    <= gen_2;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_read) begin
                data_q  <= head_half;
                words_q <= words_q + 32'd1;
                half_q  <= !half_q;
                if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end else if (do_underrun) begin
                data_q <= 32'h0;
                if (under_q != 32'hFFFF_FFFF) begin
                    under_q <= under_q + 32'd1;
                end
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

    // Timer is untouched by reset_pattern.
    always_ff @(posedge okClk) begin
        if (reset) begin
            clk_counts_q <= 64'h0;
            timer_on_q   <= 1'b0;
        end else begin
            if (start_timer || timer_on_q) begin
                clk_counts_q <= clk_counts_q + 64'd1;
            end
            if (stop_timer) begin
                timer_on_q <= 1'b0;
            end else if (start_timer) begin
                timer_on_q <= 1'b1;
            end
        end
    end

    assign pipe_out_data  = data_q;
    assign clk_counts     = clk_counts_q;
    assign timer_on       = timer_on_q;
    assign words_read     = words_q;
    assign underrun_count = under_q;
    assign buf_empty      = empty_q;

endmodule

// File: tb/tb_read_nonsym_pattern_source.sv
module tb_read_nonsym_pattern_source;

    logic        okClk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pattern_mode = 32'h0;
    logic        reset_pattern = 1'b0;
    logic        start_timer = 1'b0;
    logic        stop_timer = 1'b0;
    logic        pipe_out_read = 1'b0;
    logic [31:0] pipe_out_data;
    logic [63:0] clk_counts;
    logic        timer_on;
    logic [31:0] words_read;
    logic [31:0] underrun_count;
    logic        buf_empty;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    read_nonsym_pattern_source #(
        .DEPTH_LOG2(4),
        .LFSR_SEED (32'h0000_0001)
    ) dut (
        .okClk         (okClk),
        .reset         (reset),
        .pattern_mode  (pattern_mode),
        .reset_pattern (reset_pattern),
        .start_timer   (start_timer),
        .stop_timer    (stop_timer),
        .pipe_out_read (pipe_out_read),
        .pipe_out_data (pipe_out_data),
        .clk_counts    (clk_counts),
        .timer_on      (timer_on),
        .words_read    (words_read),
        .underrun_count(underrun_count),
        .buf_empty     (buf_empty)
    );

    always #5 okClk = ~okClk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [4];

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge okClk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset_pattern(input logic [1:0] m);
        pattern_mode  = {30'h0, m};
        reset_pattern = 1'b1;
        tick();
        reset_pattern = 1'b0;
        pattern_mode  = 32'h0;
    endtask

    initial begin
        logic [31:0] exp_w;

        vecs[0] = '{mode: 2'd0, exp0: 32'h0000_0000, exp1: 32'h0000_0001, exp2: 32'h0000_0002};
        vecs[1] = '{mode: 2'd1, exp0: 32'h0000_0001, exp1: 32'h8020_0003, exp2: 32'hC030_0002};
        vecs[2] = '{mode: 2'd2, exp0: 32'h0000_0001, exp1: 32'h0000_0002, exp2: 32'h0000_0004};
        vecs[3] = '{mode: 2'd3, exp0: 32'hA5A5_A5A5, exp1: 32'h5A5A_5A5A, exp2: 32'hA5A5_A5A5};

        // Reset state, with other inputs active to show reset overrides them.
        reset = 1'b1;
        start_timer = 1'b1;
        pipe_out_read = 1'b1;
        tick();
        tick();
        start_timer = 1'b0;
        pipe_out_read = 1'b0;
        check("rst_data", 64'(pipe_out_data), 64'h0);
        check("rst_counts", clk_counts, 64'h0);
        check("rst_timer_on", 64'(timer_on), 64'h0);
        check("rst_words", 64'(words_read), 64'h0);
        check("rst_underrun", 64'(underrun_count), 64'h0);
        check("rst_empty", 64'(buf_empty), 64'h1);
        reset = 1'b0;

        // Mode 0 after reset, six back-to-back reads.
        repeat (20) tick();
        pipe_out_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("m0_word%0d", i), 64'(pipe_out_data), 64'(i));
        end
        pipe_out_read = 1'b0;
        check("m0_words_read", 64'(words_read), 64'd6);
        tick();
        check("hold_data", 64'(pipe_out_data), 64'd5);
        check("hold_words", 64'(words_read), 64'd6);

        // Table: each mode reseeded, first three words.
        for (int v = 0; v < 4; v++) begin
            do_reset_pattern(vecs[v].mode);
            check($sformatf("v%0d_empty_after_rp", v), 64'(buf_empty), 64'h1);
            check($sformatf("v%0d_words_clr", v), 64'(words_read), 64'h0);
            repeat (20) tick();
            pipe_out_read = 1'b1;
            tick();
            check($sformatf("v%0d_w0", v), 64'(pipe_out_data), 64'(vecs[v].exp0));
            check($sformatf("v%0d_ne0", v), 64'(buf_empty), 64'h0);
            tick();
            check($sformatf("v%0d_w1", v), 64'(pipe_out_data), 64'(vecs[v].exp1));
            check($sformatf("v%0d_ne1", v), 64'(buf_empty), 64'h0);
            tick();
            check($sformatf("v%0d_w2", v), 64'(pipe_out_data), 64'(vecs[v].exp2));
            check($sformatf("v%0d_ne2", v), 64'(buf_empty), 64'h0);
            pipe_out_read = 1'b0;
            check($sformatf("v%0d_words", v), 64'(words_read), 64'd3);
        end

        // Read right after reset_pattern underruns, then p0 after refill.
        do_reset_pattern(2'd2);
        pipe_out_read = 1'b1;
        tick();
        pipe_out_read = 1'b0;
        check("ur_data", 64'(pipe_out_data), 64'h0);
        check("ur_count", 64'(underrun_count), 64'd1);
        check("ur_words", 64'(words_read), 64'd0);
        repeat (3) tick();
        pipe_out_read = 1'b1;
        tick();
        pipe_out_read = 1'b0;
        check("ur_refill_p0", 64'(pipe_out_data), 64'd1);
        check("ur_count_hold", 64'(underrun_count), 64'd1);

        // Reset_pattern with a simultaneous read: ignored, no underrun.
        pattern_mode  = 32'h2;
        reset_pattern = 1'b1;
        pipe_out_read = 1'b1;
        tick();
        reset_pattern = 1'b0;
        pipe_out_read = 1'b0;
        check("rp_read_ignored", 64'(underrun_count), 64'd0);
        check("rp_words_ignored", 64'(words_read), 64'd0);

        // Mode 2 continuous reads for 100 cycles.
        repeat (3) tick();
        exp_w = 32'h1;
        pipe_out_read = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check($sformatf("walk%0d", i), 64'(pipe_out_data), 64'(exp_w));
            exp_w = {exp_w[30:0], exp_w[31]};
        end
        pipe_out_read = 1'b0;
        check("walk_no_underrun", 64'(underrun_count), 64'd0);
        check("walk_words", 64'(words_read), 64'd100);

        // Mode 3, reset asserted at word 17.
        do_reset_pattern(2'd3);
        repeat (20) tick();
        exp_w = 32'hA5A5_A5A5;
        pipe_out_read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("m3_w%0d", i), 64'(pipe_out_data), 64'(exp_w));
            exp_w = ~exp_w;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pipe_out_read = 1'b0;
        check("mr_data", 64'(pipe_out_data), 64'h0);
        check("mr_words", 64'(words_read), 64'h0);
        check("mr_underrun", 64'(underrun_count), 64'h0);
        check("mr_empty", 64'(buf_empty), 64'h1);
        repeat (5) tick();
        pipe_out_read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("mr_m0_w%0d", i), 64'(pipe_out_data), 64'(i));
        end
        pipe_out_read = 1'b0;
        check("mr_words_after", 64'(words_read), 64'd16);

        // Timer: start, 10 idle cycles, stop together with start.
        start_timer = 1'b1;
        tick();
        start_timer = 1'b0;
        check("tmr_on", 64'(timer_on), 64'h1);
        check("tmr_count1", clk_counts, 64'd1);
        repeat (10) tick();
        start_timer = 1'b1;
        stop_timer  = 1'b1;
        tick();
        start_timer = 1'b0;
        stop_timer  = 1'b0;
        check("tmr_off", 64'(timer_on), 64'h0);
        check("tmr_count12", clk_counts, 64'd12);
        tick();
        check("tmr_hold", clk_counts, 64'd12);

        // reset_pattern leaves the timer running.
        start_timer = 1'b1;
        tick();
        start_timer = 1'b0;
        do_reset_pattern(2'd0);
        check("tmr_rp_on", 64'(timer_on), 64'h1);
        check("tmr_rp_count", clk_counts, 64'd14);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/read_nonsym_pattern_source.md
READ_NONSYM_PATTERN_SOURCE -- requirements
Module: read_nonsym_pattern_source

Interface
REQ-001 Parameters (name, default, meaning), SHALL be exactly:
- DEPTH_LOG2, 4, log2 of buffer depth in 64-bit entries (16 entries).
- LFSR_SEED, 32'h0000_0001, LFSR value loaded at reset/reset_pattern.

REQ-002 Ports (name, direction, width, meaning), SHALL be exactly:
- okClk, in, 1, single clock.
- reset, in, 1, synchronous active-high reset.
- pattern_mode, in, 32, [1:0] selects pattern; [31:2] ignored.
- reset_pattern, in, 1, one-cycle pulse: latch mode, reseed generator, flush buffer.
- start_timer, in, 1, one-cycle pulse.
- stop_timer, in, 1, one-cycle pulse.
- pipe_out_read, in, 1, pipe-out read strobe; one 32-bit word per asserted cycle.
- pipe_out_data, out, 32, read data.
- clk_counts, out, 64, timer count.
- timer_on, out, 1, timer running.
- words_read, out, 32, successful 32-bit reads, wraps.
- underrun_count, out, 32, reads while empty, saturates at 32'hFFFF_FFFF.
- buf_empty, out, 1, no 32-bit half available.

Function
REQ-003 Generator SHALL produce a 32-bit sequence p0,p1,p2,... per latched mode:
- 0: counter, p0=0, p(n+1)=p(n)+1 mod 2^32.
- 1: Galois LFSR, taps x^32+x^22+x^2+x+1, p0=LFSR_SEED.
- 2: walking one, p0=1, rotate left by 1.
- 3: constant, alternating 32'hA5A5_A5A5 / 32'h5A5A_5A5A starting A5.
REQ-004 Each buffer push SHALL write the 64-bit entry {p(2k), p(2k+1)} and advance the generator by two steps in one cycle.
REQ-005 Push SHALL occur every cycle the buffer is not full (no bubbles); full is 2^DEPTH_LOG2 entries.
REQ-006 Readout SHALL present [63:32] of the head entry first, then [31:0], then pop the entry; the host sees p0,p1,p2,... in order.
REQ-007 If pipe_out_read=1 and a half is available, the half SHALL appear on pipe_out_data at the next rising edge (latency 1), words_read SHALL increment, and the half pointer SHALL advance.
REQ-008 If pipe_out_read=1 and buf_empty=1, pipe_out_data SHALL become 32'h0; underrun_count SHALL increment (saturating); words_read and the sequence SHALL NOT advance.
REQ-009 Same-cycle push and pop of the last half SHALL both take effect; occupancy stays consistent and full blocks only the push.
REQ-010 pipe_out_data SHALL hold its value when pipe_out_read=0.
REQ-011 buf_empty SHALL be 1 exactly when entry count is 0; it is registered and reflects state after the current edge.
REQ-012 Timer, each cycle:
- start_timer sets timer_on=1.
- stop_timer clears timer_on; stop wins over a simultaneous start.
- clk_counts increments by 1 in any cycle where start_timer=1 or timer_on=1 (before update), including the stop cycle; wraps at 2^64.
REQ-013 reset_pattern SHALL:
- latch pattern_mode[1:0].
- reseed the generator per REQ-003.
- empty the buffer and clear the half pointer.
- clear underrun_count and words_read.
- leave timer state unchanged.
Any pipe_out_read in the same cycle SHALL be treated as underrun-free and ignored. The first push occurs on the following cycle.

Reset
REQ-014 On reset=1 at a rising edge: all outputs zero, buf_empty=1, latched mode=0, LFSR=LFSR_SEED; reset overrides every other input that cycle.
REQ-015 Reset asserted mid-transfer SHALL discard buffered data; after release, the sequence restarts at p0 of mode 0.

Verification
REQ-016 Reset, wait 20 cycles, read 6 words back-to-back in mode 0 -> data 0,1,2,3,4,5 each one cycle after its strobe; words_read=6.
REQ-017 pattern_mode=1, reset_pattern, read 3 words -> 32'h0000_0001 followed by two correct LFSR successors; buf_empty=0 throughout.
REQ-018 reset_pattern then pipe_out_read in the following cycle -> that read returns 32'h0 and underrun_count=1; next read after refill returns p0.
REQ-019 Continuous reads for 100 cycles in mode 2 -> no underrun after initial fill, data rotates 1,2,4,... with wrap from 32'h8000_0000 to 1.
REQ-020 start_timer, 10 idle cycles, stop_timer with start_timer the same cycle -> timer_on=0; clk_counts=12.
REQ-021 Mode 3, read 33 words, assert reset at word 17 -> outputs zero; subsequent reads give mode-0 sequence from 0.
